// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store bridge between a multi-cycle
// controller and a word-wide memory port. One request is accepted at a time.
// The unit checks it for legality, drives a word-aligned memory access with
// byte strobes, and returns either extended load data or an error. An error
// covers a misaligned access, an illegal funct3, or a timeout.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready request handshake (accepted when both high)
//   req_we/req_addr/req_wdata/req_funct3  access attributes (RV32I funct3)
//   busy                high while a transaction is in flight
//   rsp_valid/rsp_err   one-cycle completion pulse and its error flag
//   rsp_rdata           last completed load value (0 after an error)
//   mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb  memory request, held in REQ
//   mem_ack/mem_rdata   memory completion and read word
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        req_ready,
  output logic        busy,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  // Counter only needs to hold 0..TIMEOUT-1; the last REQ cycle is TIMEOUT-1.
  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t state, state_n;

  logic [CW-1:0] cnt;
  logic          txn_we;
  logic [2:0]    txn_funct3;
  logic [1:0]    txn_off;

  logic accept_c, legal_c, ack_c, expire_c;

  // Legal funct3 for the direction, and natural alignment for the size.
  function automatic logic is_legal(input logic we, input logic [2:0] f3,
                                    input logic [1:0] off);
    logic ok_f3;
    logic aligned;
    ok_f3   = 1'b0;
    aligned = 1'b1;
    if (we) ok_f3 = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    else    ok_f3 = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                    (f3 == 3'b100) || (f3 == 3'b101);
    case (f3[1:0])
      2'b01:   aligned = ~off[0];
      2'b10:   aligned = (off == 2'b00);
      default: aligned = 1'b1;
    endcase
    return ok_f3 & aligned;
  endfunction

  // Pick the addressed byte/halfword lane and extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] store_strobe(input logic [2:0] f3,
                                              input logic [1:0] off);
    logic [3:0] s;
    case (f3[1:0])
      2'b00:   s = 4'b0001 << off;
      2'b01:   s = 4'b0011 << off;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  // Replicate narrow store data across all lanes so the strobe selects it.
  function automatic logic [31:0] store_data(input logic [2:0]  f3,
                                             input logic [31:0] wdata);
    logic [31:0] d;
    case (f3[1:0])
      2'b00:   d = {4{wdata[7:0]}};
      2'b01:   d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  assign accept_c = req_valid & (state == IDLE);
  assign legal_c  = is_legal(req_we, req_funct3, req_addr[1:0]);
  assign ack_c    = (state == REQ) & mem_ack;
  assign expire_c = (state == REQ) & ~mem_ack & (cnt == CNT_LAST);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept_c) state_n = legal_c ? REQ : RESP;
      REQ:     if (ack_c || expire_c) state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Registered outputs, transaction capture and timeout counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_rdata  <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
      cnt        <= '0;
      txn_we     <= 1'b0;
      txn_funct3 <= '0;
      txn_off    <= '0;
    end else begin
      req_ready <= (state_n == IDLE);
      busy      <= (state_n != IDLE);
      rsp_valid <= (state_n == RESP);
      rsp_err   <= 1'b0;

      if (accept_c) begin
        txn_we     <= req_we;
        txn_funct3 <= req_funct3;
        txn_off    <= req_addr[1:0];
        cnt        <= '0;
        if (legal_c) begin
          mem_req   <= 1'b1;
          mem_we    <= req_we;
          mem_addr  <= {req_addr[31:2], 2'b00};
          mem_wdata <= req_we ? store_data(req_funct3, req_wdata) : 32'd0;
          mem_wstrb <= req_we ? store_strobe(req_funct3, req_addr[1:0]) : 4'b0000;
        end else begin
          rsp_err   <= 1'b1;
          rsp_rdata <= '0;
        end
      end

      if (ack_c) begin
        mem_req   <= 1'b0;
        mem_we    <= 1'b0;
        mem_wstrb <= 4'b0000;
        if (!txn_we) rsp_rdata <= load_extract(mem_rdata, txn_funct3, txn_off);
      end else if (expire_c) begin
        mem_req   <= 1'b0;
        mem_we    <= 1'b0;
        mem_wstrb <= 4'b0000;
        rsp_err   <= 1'b1;
        rsp_rdata <= '0;
      end else if (state == REQ) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a cycle-numbered
// transaction model.
module tb_mem_access_unit;

  localparam int TO  = 4;
  localparam int INF = 32'h7fff_ffff;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        req_ready, busy, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_funct3(req_funct3),
    .req_ready(req_ready), .busy(busy), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Model state, expressed as absolute cycle numbers.
  int          free_at = 0;   // first cycle the unit is ready again
  int          win_lo  = 1;   // mem_req expected in cycles win_lo..win_hi
  int          win_hi  = 0;
  int          rsp_at  = -1;  // cycle of the rsp_valid pulse
  logic        exp_err = 1'b0;
  logic [31:0] exp_rdata = 32'd0;
  logic        m_we = 1'b0;
  logic [2:0]  m_f3 = 3'd0;
  logic [31:0] m_addr = 32'd0;
  logic [31:0] m_wdata = 32'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
  endtask

  function automatic bit tb_legal(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    int unsigned sz;
    bit ok;
    if (we) ok = (f3 <= 3'd2);
    else    ok = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    sz = 32'd1 << f3[1:0];
    return ok && ((addr % sz) == 0);
  endfunction

  function automatic logic [31:0] tb_extract(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
    int unsigned off;
    logic [31:0] w, v;
    off = addr % 4;
    w   = word >> (8 * off);
    case (f3)
      3'd0: begin v = w & 32'hFF;   if (v >= 32'h80)   v = v | 32'hFFFF_FF00; end
      3'd1: begin v = w & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF_0000; end
      3'd4: v = w & 32'hFF;
      3'd5: v = w & 32'hFFFF;
      default: v = word;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] tb_strobe(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    int unsigned sz;
    if (!we) return 4'd0;
    sz = 32'd1 << f3[1:0];
    return 4'(((32'd1 << sz) - 1) << (addr % 4));
  endfunction

  function automatic logic [31:0] tb_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'd0:    return (d & 32'hFF) * 32'h0101_0101;
      2'd1:    return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  // Transaction model: advances at each rising edge using the inputs of the
  // cycle that just ended.
  always @(posedge clk) begin : model
    int n;
    n = cyc;
    if (reset) begin
      free_at   = n + 1;
      win_lo    = 1;
      win_hi    = 0;
      rsp_at    = -1;
      exp_err   = 1'b0;
      exp_rdata = 32'd0;
    end else begin
      if (n >= win_lo && n <= win_hi) begin
        if (mem_ack) begin
          rsp_at  = n + 1;
          exp_err = 1'b0;
          if (!m_we) exp_rdata = tb_extract(m_f3, m_addr, mem_rdata);
          win_hi  = n;
          free_at = n + 2;
        end else if (n == win_hi) begin
          rsp_at    = n + 1;
          exp_err   = 1'b1;
          exp_rdata = 32'd0;
          free_at   = n + 2;
        end
      end
      if (n >= free_at && req_valid) begin
        m_we    = req_we;
        m_f3    = req_funct3;
        m_addr  = req_addr;
        m_wdata = req_wdata;
        if (tb_legal(req_we, req_funct3, req_addr)) begin
          win_lo  = n + 1;
          win_hi  = n + TO;
          free_at = INF;
        end else begin
          rsp_at    = n + 1;
          exp_err   = 1'b1;
          exp_rdata = 32'd0;
          free_at   = n + 2;
        end
      end
    end
    cyc = n + 1;
  end

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin : compare
    logic e_ready, e_req, e_rv;
    if (reset) begin
      chk("rst_req_ready", req_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_wstrb", mem_wstrb, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
    end else begin
      e_ready = (cyc >= free_at);
      e_req   = (cyc >= win_lo) && (cyc <= win_hi);
      e_rv    = (cyc == rsp_at);
      chk("req_ready", req_ready, e_ready);
      chk("busy", busy, !e_ready);
      chk("mem_req", mem_req, e_req);
      chk("rsp_valid", rsp_valid, e_rv);
      chk("rsp_err", rsp_err, e_rv && exp_err);
      chk("rsp_rdata", rsp_rdata, exp_rdata);
      if (e_req) begin
        chk("mem_addr", mem_addr, m_addr & 32'hFFFF_FFFC);
        chk("mem_we", mem_we, m_we);
        chk("mem_wstrb", mem_wstrb, tb_strobe(m_we, m_f3, m_addr));
        if (m_we) chk("mem_wdata", mem_wdata, tb_wdata(m_f3, m_wdata));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic we, input logic [31:0] a,
                         input logic [2:0] f3, input logic [31:0] d);
    req_valid  = v;
    req_we     = we;
    req_addr   = a;
    req_funct3 = f3;
    req_wdata  = d;
  endtask

  logic [2:0] legal_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  initial begin
    reset = 1'b1;
    set_req(0, 0, 0, 0, 0);
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;

    @(negedge clk);
    chk("lit_rst_ready", req_ready, 1);
    chk("lit_rst_mem_req", mem_req, 0);
    step();
    reset = 1'b0;
    step();

    // LB at 0x103, ack in the first REQ cycle
    set_req(1, 0, 32'h103, 3'b000, 32'h5555_5555);
    step();
    req_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h80FF_1234;
    @(negedge clk);
    chk("lb_mem_req", mem_req, 1);
    chk("lb_mem_addr", mem_addr, 32'h100);
    step();
    mem_ack = 1'b0; mem_rdata = $urandom;
    @(negedge clk);
    chk("lb_rsp_valid", rsp_valid, 1);
    chk("lb_rsp_err", rsp_err, 0);
    chk("lb_rsp_rdata", rsp_rdata, 32'hFFFF_FF80);
    step();

    // SH at 0x202
    set_req(1, 1, 32'h202, 3'b001, 32'hAAAA_BEEF);
    step();
    req_valid = 1'b0; mem_ack = 1'b1;
    @(negedge clk);
    chk("sh_mem_wdata", mem_wdata, 32'hBEEF_BEEF);
    chk("sh_mem_wstrb", mem_wstrb, 4'b1100);
    chk("sh_mem_we", mem_we, 1);
    step();
    mem_ack = 1'b0;
    @(negedge clk);
    chk("sh_rsp_valid", rsp_valid, 1);
    chk("sh_rsp_rdata", rsp_rdata, 32'hFFFF_FF80);
    step();

    // Misaligned LW, then illegal funct3 011
    set_req(1, 0, 32'h105, 3'b010, 32'd0);
    step();
    req_valid = 1'b0;
    @(negedge clk);
    chk("mis_mem_req", mem_req, 0);
    chk("mis_rsp_valid", rsp_valid, 1);
    chk("mis_rsp_err", rsp_err, 1);
    chk("mis_rsp_rdata", rsp_rdata, 0);
    step();
    @(negedge clk);
    chk("mis_after_valid", rsp_valid, 0);
    chk("mis_after_err", rsp_err, 0);
    step();
    set_req(1, 0, 32'h100, 3'b011, 32'd0);
    step();
    req_valid = 1'b0;
    @(negedge clk);
    chk("f3_mem_req", mem_req, 0);
    chk("f3_rsp_valid", rsp_valid, 1);
    chk("f3_rsp_err", rsp_err, 1);
    step();

    // LHU at 0x002 with ack withheld: timeout after TO REQ cycles
    set_req(1, 0, 32'h002, 3'b101, 32'd0);
    step();
    req_valid = 1'b0;
    for (int i = 0; i < TO; i++) begin
      @(negedge clk);
      chk("to_mem_req", mem_req, 1);
      step();
    end
    mem_ack = 1'b1;
    @(negedge clk);
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_rsp_err", rsp_err, 1);
    chk("to_mem_req_off", mem_req, 0);
    step();
    mem_ack = 1'b0;
    @(negedge clk);
    chk("to_late_ack_valid", rsp_valid, 0);
    chk("to_ready", req_ready, 1);
    step();
    set_req(1, 0, 32'h004, 3'b010, 32'd0);
    step();
    req_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("to_next_mem_addr", mem_addr, 32'h4);
    step();
    mem_ack = 1'b0;
    @(negedge clk);
    chk("to_next_rsp_err", rsp_err, 0);
    chk("to_next_rsp_rdata", rsp_rdata, 32'h1234_5678);
    step();

    // Reset during REQ, then a stray ack
    set_req(1, 0, 32'h008, 3'b010, 32'd0);
    step();
    req_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rr_mem_req", mem_req, 0);
    chk("rr_ready", req_ready, 1);
    step();
    reset = 1'b0; mem_ack = 1'b1; mem_rdata = $urandom;
    @(negedge clk);
    chk("rr_rsp_valid", rsp_valid, 0);
    chk("rr_mem_req_after", mem_req, 0);
    step();
    mem_ack = 1'b0;
    @(negedge clk);
    chk("rr_rsp_valid2", rsp_valid, 0);
    chk("rr_ready2", req_ready, 1);
    step();

    // Back-to-back LW with req_valid held high throughout
    set_req(1, 0, 32'h010, 3'b010, 32'd0);
    step();
    mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    @(negedge clk);
    chk("b2b_req1", mem_req, 1);
    step();
    mem_ack = 1'b0;
    @(negedge clk);
    chk("b2b_rsp1", rsp_valid, 1);
    chk("b2b_rdata1", rsp_rdata, 32'h1111_1111);
    chk("b2b_no_req", mem_req, 0);
    step();
    req_addr = 32'h020;
    @(negedge clk);
    chk("b2b_gap", rsp_valid, 0);
    step();
    mem_ack = 1'b1; mem_rdata = 32'h2222_2222;
    @(negedge clk);
    chk("b2b_req2_addr", mem_addr, 32'h20);
    chk("b2b_req2", mem_req, 1);
    step();
    mem_ack = 1'b0;
    @(negedge clk);
    chk("b2b_rsp2", rsp_valid, 1);
    chk("b2b_rdata2", rsp_rdata, 32'h2222_2222);
    step();
    req_valid = 1'b0;
    step();
    @(negedge clk);
    chk("b2b_no_third", mem_req, 0);
    step();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset     = 1'b0;
      req_valid = ($urandom % 2) == 0;
      req_we    = ($urandom % 2) == 0;
      req_addr  = $urandom;
      if ($urandom % 2) req_addr[1:0] = 2'b00;
      if ($urandom % 4 == 0) req_funct3 = 3'($urandom % 8);
      else if (req_we)       req_funct3 = legal_f3[$urandom % 3];
      else                   req_funct3 = legal_f3[$urandom % 5];
      req_wdata = $urandom;
      mem_ack   = ($urandom % 3) == 0;
      mem_rdata = $urandom;
      if ($urandom % 400 == 0) #2 reset = 1'b1;
      step();
    end
    reset = 1'b0;
    req_valid = 1'b0;
    mem_ack = 1'b0;
    repeat (8) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
